// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types for the configurable SPI master. Holds the FSM
//                state encoding and the per-transfer mode bundle that is
//                latched when a transfer is accepted.
//  Contents    : spi_state_e  - IDLE / SETUP / XFER / HOLD
//                spi_mode_t   - {cpol, cpha, lsb_first}
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sclk_gen
//  Description : SCLK divider. While enabled, counts CLK_DIV clk cycles per
//                SCLK half-period and toggles the SCLK phase at each boundary.
//                The edge strobes are high in the clk cycle whose closing
//                posedge makes the SCLK edge visible, so logic that acts on a
//                strobe samples/drives at the same instant as the SCLK edge.
//  Ports       : clk, reset        - system clock, async active-high reset
//                en_i              - run the divider (only in XFER)
//                cpol_i            - SCLK idle level
//                sclk_o            - SCLK level
//                lead_edge_o       - leading-edge strobe (away from idle)
//                trail_edge_o      - trailing-edge strobe (back to idle)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic cpol_i,
    output logic sclk_o,
    output logic lead_edge_o,
    output logic trail_edge_o
);

    localparam int             CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;   // 0: SCLK at idle level, 1: SCLK at active level
    logic             tick_w;

    assign tick_w = en_i && (cnt_q == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (tick_w) begin
            cnt_q   <= '0;
            level_q <= ~level_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // A leading edge always starts from the idle phase.
    assign lead_edge_o  = tick_w & ~level_q;
    assign trail_edge_o = tick_w &  level_q;
    assign sclk_o       = cpol_i ^ level_q;

endmodule : spi_sclk_gen
`default_nettype wire

// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_cfg
//  Description : Single-transfer SPI master with compile-time width, divider
//                and chip-select count, and per-transfer CPOL/CPHA/bit order.
//                Sequence per transfer: SETUP (CS asserted, CLK_DIV cycles),
//                XFER (2*DATA_WIDTH SCLK edges), HOLD (CLK_DIV cycles), then a
//                done cycle in IDLE where CS releases and rx_data updates.
//  Ports       : clk, reset            - system clock, async active-high reset
//                start                 - transfer request (IDLE only)
//                tx_data, cs_sel,
//                cpol, cpha, lsb_first - transfer setup, latched at accept
//                busy, done            - status / one-cycle completion pulse
//                rx_data               - received word, held until next done
//                sclk, mosi, miso      - SPI bus
//                cs_n                  - one-hot active-low chip selects
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int CLK_DIV    = 2,
    parameter  int NUM_CS     = 1,
    localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CSW-1:0]        cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int               DIV_W     = $clog2(CLK_DIV + 1);
    localparam int               EDGE_W    = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    spi_state_e            state_q;
    spi_mode_t             mode_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [DATA_WIDTH-1:0] tx_sh_q;
    logic [DATA_WIDTH-1:0] rx_sh_q;
    logic                  mosi_q;
    logic [NUM_CS-1:0]     cs_n_q;
    logic [DIV_W-1:0]      div_q;
    logic [EDGE_W-1:0]     edge_q;

    logic                  lead_edge_w;
    logic                  trail_edge_w;
    logic [NUM_CS-1:0]     cs_dec_w;

    // ------------------------------------------------------------------
    // Bit-order helpers: the same orientation drives tx and assembles rx.
    // ------------------------------------------------------------------
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                        input logic lsb);
        return lsb ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                       input logic lsb, input logic b);
        return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
    endfunction

    // Out-of-range cs_sel simply matches no line, leaving every select high.
    always_comb begin
        cs_dec_w = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CSW'(i)) begin
                cs_dec_w[i] = 1'b0;
            end
        end
    end

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .reset        (reset),
        .en_i         (state_q == XFER),
        .cpol_i       (mode_q.cpol),
        .sclk_o       (sclk),
        .lead_edge_o  (lead_edge_w),
        .trail_edge_o (trail_edge_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            div_q     <= '0;
            edge_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    // The done cycle sits in IDLE with busy still high; start is
                    // not accepted until busy has dropped.
                    if (done_q) begin
                        busy_q <= 1'b0;
                    end else if (start) begin
                        mode_q  <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
                        busy_q  <= 1'b1;
                        cs_n_q  <= cs_dec_w;
                        div_q   <= '0;
                        edge_q  <= '0;
                        rx_sh_q <= '0;
                        if (!cpha) begin
                            // CPHA=0: first bit must be on the line before the
                            // first (sampling) edge.
                            mosi_q  <= first_bit(tx_data, lsb_first);
                            tx_sh_q <= shift_out(tx_data, lsb_first);
                        end else begin
                            tx_sh_q <= tx_data;
                        end
                        state_q <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        state_q <= XFER;
                    end else begin
                        div_q   <= div_q + 1'b1;
                    end
                end

                XFER: begin
                    if (lead_edge_w) begin
                        if (mode_q.cpha) begin
                            mosi_q  <= first_bit(tx_sh_q, mode_q.lsb_first);
                            tx_sh_q <= shift_out(tx_sh_q, mode_q.lsb_first);
                        end else begin
                            rx_sh_q <= shift_in(rx_sh_q, mode_q.lsb_first, miso);
                        end
                    end
                    if (trail_edge_w) begin
                        if (mode_q.cpha) begin
                            rx_sh_q <= shift_in(rx_sh_q, mode_q.lsb_first, miso);
                        end else if (edge_q != EDGE_LAST) begin
                            mosi_q  <= first_bit(tx_sh_q, mode_q.lsb_first);
                            tx_sh_q <= shift_out(tx_sh_q, mode_q.lsb_first);
                        end
                    end
                    if (lead_edge_w || trail_edge_w) begin
                        if (edge_q == EDGE_LAST) begin
                            edge_q  <= '0;
                            div_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            edge_q  <= edge_q + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (div_q == DIV_LAST) begin
                        div_q     <= '0;
                        cs_n_q    <= '1;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sh_q;
                        state_q   <= IDLE;
                    end else begin
                        div_q     <= div_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule : spi_master_cfg
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_cfg
//  Description : Directed self-checking bench for spi_master_cfg. Instance u0
//                (8-bit, divider 2, four selects) talks to a behavioural SPI
//                slave; instance u1 (16-bit, divider 1) runs in loopback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_cfg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // u0 : DATA_WIDTH=8, CLK_DIV=2, NUM_CS=4
    logic       start0, cpol0, cpha0, lsb0;
    logic [7:0] tx0, rx0;
    logic [1:0] cs0;
    logic       busy0, done0, sclk0, mosi0, miso0;
    logic [3:0] csn0;

    // u1 : DATA_WIDTH=16, CLK_DIV=1, NUM_CS=1, mosi looped to miso
    logic        start1;
    logic [15:0] tx1, rx1;
    logic        cs1;
    logic        busy1, done1, sclk1, mosi1;
    logic [0:0]  csn1;

    int checks   = 0;
    int failures = 0;

    spi_master_cfg #(.DATA_WIDTH(8), .CLK_DIV(2), .NUM_CS(4)) u0 (
        .clk(clk), .reset(reset), .start(start0), .tx_data(tx0), .cs_sel(cs0),
        .cpol(cpol0), .cpha(cpha0), .lsb_first(lsb0), .busy(busy0), .done(done0),
        .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(csn0)
    );

    spi_master_cfg #(.DATA_WIDTH(16), .CLK_DIV(1), .NUM_CS(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .tx_data(tx1), .cs_sel(cs1),
        .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .busy(busy1), .done(done1),
        .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1), .cs_n(csn1)
    );

    // ------------------------------------------------------------------
    // Behavioural slave on u0: shifts s_data out, records mosi on its
    // sampling edges (first bit on the wire ends up in cap[7]).
    // ------------------------------------------------------------------
    logic [7:0] s_data, cap;
    logic       s_cpol, s_cpha, s_lsb, s_en, s_en_l, s_last;
    int         s_p;

    initial begin
        s_en_l = 1'b0;
        s_last = 1'b0;
        s_p    = 0;
        cap    = '0;
    end

    always @(sclk0, s_en) begin
        if (s_en && !s_en_l) begin
            s_p = s_cpha ? -1 : 0;
            cap = '0;
        end else if (s_en && (sclk0 !== s_last)) begin
            if (sclk0 !== s_cpol) begin          // leading edge
                if (s_cpha) s_p = s_p + 1;
                else        cap = {cap[6:0], mosi0};
            end else begin                       // trailing edge
                if (s_cpha) cap = {cap[6:0], mosi0};
                else        s_p = s_p + 1;
            end
        end
        s_last = sclk0;
        s_en_l = s_en;
    end

    always_comb begin
        miso0 = 1'b0;
        if (s_p >= 0 && s_p < 8) begin
            miso0 = s_lsb ? s_data[s_p[2:0]] : s_data[3'd7 - s_p[2:0]];
        end
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after
    // the cycle budget). inj_at / rst_at inject a stray start or a reset at
    // that cycle after accept (0 = none).
    task automatic run_xfer(input logic [7:0] tx, input logic [1:0] cs, input logic pol,
                            input logic pha, input logic lsb, input logic [7:0] sdata,
                            input int inj_at, input int rst_at);
        int         kd;
        logic [3:0] exp_cs;
        logic [7:0] exp_seq;
        exp_cs     = 4'hF;
        exp_cs[cs] = 1'b0;
        exp_seq    = lsb ? rev8(tx) : tx;
        tx0 = tx; cs0 = cs; cpol0 = pol; cpha0 = pha; lsb0 = lsb;
        s_data = sdata; s_cpol = pol; s_cpha = pha; s_lsb = lsb;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        s_en   = 1'b1;
        chk("busy_after_accept", 32'(busy0), 1);
        chk("cs_n_setup", 32'(csn0), 32'(exp_cs));
        chk("sclk_setup_level", 32'(sclk0), 32'(pol));
        if (!pha) chk("mosi_first_bit", 32'(mosi0), 32'(lsb ? tx[0] : tx[7]));
        kd = 0;
        for (int k = 1; k <= 60 && kd == 0; k++) begin
            if (done0) begin
                kd = k;
            end else begin
                if (k == 36 && rst_at == 0) begin
                    chk("cs_n_hold", 32'(csn0), 32'(exp_cs));
                    chk("sclk_hold", 32'(sclk0), 32'(pol));
                end
                if (k == inj_at)     begin tx0 = 8'hFF; start0 = 1'b1; end
                if (k == inj_at + 1) begin tx0 = tx;    start0 = 1'b0; end
                if (k == rst_at) begin
                    reset = 1'b1;
                    #1;
                    chk("rst_cs_n", 32'(csn0), 32'hF);
                    chk("rst_sclk", 32'(sclk0), 0);
                    chk("rst_busy", 32'(busy0), 0);
                    chk("rst_rx_data", 32'(rx0), 0);
                end
                if (k == rst_at + 1) reset = 1'b0;
                @(negedge clk);
            end
        end
        s_en = 1'b0;
        if (rst_at != 0) begin
            chk("no_done_after_reset", 32'(kd), 0);
        end else begin
            chk("done_latency", 32'(kd), 37);
            chk("busy_in_done", 32'(busy0), 1);
            chk("cs_n_released", 32'(csn0), 32'hF);
            chk("rx_data", 32'(rx0), 32'(sdata));
            chk("mosi_sequence", 32'(cap), 32'(exp_seq));
            chk("sclk_idle_done", 32'(sclk0), 32'(pol));
        end
    endtask

    initial begin
        int nd;
        int kd1;
        reset  = 1'b1;
        start0 = 1'b0; tx0 = '0; cs0 = '0; cpol0 = 1'b0; cpha0 = 1'b0; lsb0 = 1'b0;
        start1 = 1'b0; tx1 = '0; cs1 = 1'b0;
        s_en   = 1'b0; s_data = '0; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_busy", 32'(busy0), 0);
        chk("reset_done", 32'(done0), 0);
        chk("reset_rx_data", 32'(rx0), 0);
        chk("reset_sclk", 32'(sclk0), 0);
        chk("reset_mosi", 32'(mosi0), 0);
        chk("reset_cs_n", 32'(csn0), 32'hF);
        chk("reset_cs_n_u1", 32'(csn1), 1);
        chk("reset_busy_u1", 32'(busy1), 0);
        reset = 1'b0;
        @(negedge clk);

        // Mode 0, MSB first
        run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 0);
        @(negedge clk);

        // Mode 3, LSB first; SCLK must idle high afterwards
        run_xfer(8'h81, 2'd1, 1'b1, 1'b1, 1'b1, 8'hF0, 0, 0);
        @(negedge clk);
        chk("sclk_idles_high", 32'(sclk0), 1);

        // Select 2, mode 1
        run_xfer(8'h96, 2'd2, 1'b0, 1'b1, 1'b0, 8'h5A, 0, 0);
        @(negedge clk);

        // Select 3 then 2 back to back, start raised in the done cycle
        run_xfer(8'h3C, 2'd3, 1'b1, 1'b0, 1'b1, 8'h81, 0, 0);
        cs0    = 2'd2;
        start0 = 1'b1;
        @(negedge clk);
        chk("gap_busy_low", 32'(busy0), 0);
        chk("gap_cs_n_high", 32'(csn0), 32'hF);
        run_xfer(8'h42, 2'd2, 1'b0, 1'b0, 1'b0, 8'hC7, 0, 0);
        @(negedge clk);

        // Stray start five cycles into busy
        run_xfer(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 5, 0);
        nd = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done0) nd++;
        end
        chk("extra_done_count", 32'(nd), 0);
        chk("busy_after_single", 32'(busy0), 0);

        // Reset in the middle of XFER, then a normal transfer
        run_xfer(8'hC3, 2'd1, 1'b0, 1'b0, 1'b0, 8'h99, 0, 19);
        chk("post_reset_busy", 32'(busy0), 0);
        chk("post_reset_cs_n", 32'(csn0), 32'hF);
        run_xfer(8'h3C, 2'd1, 1'b0, 1'b0, 1'b0, 8'h66, 0, 0);
        @(negedge clk);

        // 16-bit, divider 1, loopback
        tx1    = 16'h8001;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        kd1    = 0;
        for (int k = 1; k <= 60 && kd1 == 0; k++) begin
            if (done1) begin
                kd1 = k;
            end else begin
                if (k == 2) chk("u1_sclk_k2", 32'(sclk1), 0);
                if (k == 3) chk("u1_sclk_k3", 32'(sclk1), 1);
                if (k == 4) chk("u1_sclk_k4", 32'(sclk1), 0);
                @(negedge clk);
            end
        end
        chk("u1_done_latency", 32'(kd1), 35);
        chk("u1_rx_loopback", 32'(rx1), 32'h8001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_master_cfg
`default_nettype wire
